gpi_event_fifo: RTL

Parametrised input-event buffer between an event source and the CPU's general-purpose input port; the reference source is the PS/2 receiver's `got_code_tick`/`dout` pair. Each write tick pushes one data word into a first-word-fall-through FIFO, so no events are lost while the CPU is busy. The CPU pops words at its own pace. The block reports occupancy and flags overflow. An optional front-end filter can discard PS/2 break sequences.

---
 rtl/gpi_event_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/gpi_event_fifo.sv
// Show-ahead event FIFO between an input event source and the CPU GPI port.
// Define GPI_BREAK_FILTER_EN to drop PS/2 break sequences (F0 xx) at the input.
module gpi_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tick,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              wr_acc;
    logic              push;
    logic              pop;
    logic              ovf_set;

`ifdef GPI_BREAK_FILTER_EN
    typedef enum logic {
        IDLE,
        BRK
    } flt_e;

    flt_e flt_q;
    flt_e flt_d;

    always_ff @(posedge clk) begin
        if (reset) flt_q <= IDLE;
        else       flt_q <= flt_d;
    end

    always_comb begin
        flt_d = flt_q;
        if (wr_tick) begin
            unique case (flt_q)
                IDLE: if (wr_data[7:0] == 8'hF0) flt_d = BRK;
                BRK:  flt_d = IDLE;
            endcase
        end
    end

    // Both the F0 prefix and the code following it are swallowed.
    always_comb begin
        wr_acc = 1'b0;
        if (wr_tick)
            wr_acc = (flt_q == IDLE) && (wr_data[7:0] != 8'hF0);
    end
`else
    assign wr_acc = wr_tick;
`endif

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rd_en && !empty;
    assign push    = wr_acc && (!full || rd_en);
    assign ovf_set = wr_acc && full && !rd_en;
    assign rd_data = empty ? '0 : mem[rp];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + ADDR_W'(1);
            if (pop)  rp <= rp + ADDR_W'(1);
            if (push && !pop)
                count <= count + (ADDR_W + 1)'(1);
            else if (pop && !push)
                count <= count - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

endmodule
